// File: rtl/lifo_reader.sv
// lifo_reader: drains an attached LIFO into a valid/ready stream.
// A start request latches the current occupancy as the burst length; words are
// popped through a 2-entry skid buffer so the sink sees 1 word/cycle when ready,
// with last_o on the final word and a done_o pulse once that word is accepted.
module lifo_reader #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    input  logic [DWIDTH-1:0] lifo_q_i,
    output logic              lifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned CW = AWIDTH + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_n;

    logic [CW-1:0]     r_len;
    logic [CW-1:0]     r_remaining;
    logic [CW-1:0]     r_sent;
    logic [DWIDTH-1:0] r_buf0;
    logic [DWIDTH-1:0] r_buf1;
    logic              r_head;
    logic [1:0]        r_cnt;
    logic              r_inflight;

    logic              w_pop;
    logic              w_start_ok;
    logic              w_last_xfer;
    logic              w_busy_n;
    logic              w_done_n;
    logic [2:0]        w_occ;
    logic              w_tail;
    logic              w_head_n;
    logic [1:0]        w_cnt_n;
    logic [DWIDTH-1:0] w_buf0_n;
    logic [DWIDTH-1:0] w_buf1_n;
    logic [CW-1:0]     w_sent_n;
    logic [CW-1:0]     w_len_m1;

    assign w_pop       = valid_o & ready_i;
    assign w_start_ok  = (r_state == ST_IDLE) & start_i & ~lifo_empty_i;
    assign w_last_xfer = w_pop & last_o;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state: a start on an empty LIFO is ignored; the burst ends on the accepted last word
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok)  w_state_n = ST_DRAIN;
            ST_DRAIN: if (w_last_xfer) w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase
    end

    // FSM outputs: pop request keeps buffered + in-flight words at or below two after this cycle's pop
    always_comb begin
        lifo_rdreq_o = 1'b0;
        w_done_n     = 1'b0;
        w_busy_n     = (w_state_n == ST_DRAIN);
        w_occ        = 3'(r_cnt) + 3'(r_inflight);
        if (r_state == ST_DRAIN) begin
            lifo_rdreq_o = (r_remaining != '0) && !lifo_empty_i
                           && (w_occ < (3'd2 + 3'(w_pop)));
            w_done_n     = w_last_xfer;
        end
    end

    // Skid buffer next state: in-flight word lands at the tail, a pop advances the head
    always_comb begin
        w_tail   = r_head ^ r_cnt[0];
        w_buf0_n = r_buf0;
        w_buf1_n = r_buf1;
        if (r_inflight) begin
            if (w_tail) w_buf1_n = lifo_q_i;
            else        w_buf0_n = lifo_q_i;
        end
        w_head_n = r_head ^ w_pop;
        w_cnt_n  = r_cnt + 2'(r_inflight) - 2'(w_pop);
        w_sent_n = r_sent + CW'(w_pop);
        w_len_m1 = r_len - CW'(1);
    end

    // Datapath and registered stream/status outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_len       <= '0;
            r_remaining <= '0;
            r_sent      <= '0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_head      <= 1'b0;
            r_cnt       <= 2'd0;
            r_inflight  <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_len       <= lifo_usedw_i;
                r_remaining <= lifo_usedw_i;
                r_sent      <= '0;
            end else begin
                if (lifo_rdreq_o) r_remaining <= r_remaining - CW'(1);
                r_sent <= w_sent_n;
            end
            r_inflight <= lifo_rdreq_o;
            r_buf0     <= w_buf0_n;
            r_buf1     <= w_buf1_n;
            r_head     <= w_head_n;
            r_cnt      <= w_cnt_n;
            data_o     <= w_head_n ? w_buf1_n : w_buf0_n;
            valid_o    <= (w_cnt_n != 2'd0);
            last_o     <= (w_cnt_n != 2'd0) && (w_sent_n == w_len_m1) && !w_start_ok;
            busy_o     <= w_busy_n;
            done_o     <= w_done_n;
        end
    end

endmodule

// File: tb/tb_lifo_reader.sv
// Bench for lifo_reader: behavioural LIFO, scoreboard of expected stream words,
// table of drain bursts plus hand-written corner sequences.
module tb_lifo_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          lifo_empty_i;
    logic [AW:0]   lifo_usedw_i;
    logic [DW-1:0] lifo_q_i = '0;
    logic          lifo_rdreq_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    always #5 clk_i = ~clk_i;

    lifo_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .lifo_empty_i (lifo_empty_i),
        .lifo_usedw_i (lifo_usedw_i),
        .lifo_q_i     (lifo_q_i),
        .lifo_rdreq_o (lifo_rdreq_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Behavioural LIFO: q valid the cycle after a pop request
    logic [DW-1:0] stack [0:15];
    logic [4:0]    top = 5'd0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_d = '0;
    logic          lifo_clr = 1'b0;
    logic          force_empty = 1'b0;

    assign lifo_usedw_i = top[AW:0];
    assign lifo_empty_i = (top == 5'd0) || force_empty;

    always @(posedge clk_i) begin
        if (lifo_clr) begin
            top <= 5'd0;
        end else if (push_en) begin
            stack[top[3:0]] <= push_d;
            top <= top + 5'd1;
        end else if (lifo_rdreq_o && top != 5'd0) begin
            lifo_q_i <= stack[4'(top - 5'd1)];
            top <= top - 5'd1;
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    typedef struct {
        int n;
        int mode;
        int base;
        int step;
        int exp_lat;
        int exp_done;
    } vec_t;

    exp_t          exp_q [$];
    logic [DW-1:0] vals [0:15];
    int            n_checks = 0;
    int            n_errs = 0;
    int            cyc = 0;
    int            n_reads = 0;
    int            n_xfer = 0;
    int            n_done = 0;
    int            done0 = 0;
    int            done_at = 0;
    int            first_valid = -1;
    int            start_cyc = 0;
    int            ready_mode = 0;
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;
    logic          prev_done = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (hold_pend) begin
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_data", 32'(data_o), 32'(hold_d));
            check("hold_last", 32'(last_o), 32'(hold_l));
        end
        hold_pend = valid_o && !ready_i;
        hold_d    = data_o;
        hold_l    = last_o;
        if (valid_o && first_valid < 0) first_valid = cyc;
        if (last_o) check("last_qualified", 32'(valid_o), 32'd1);
        if (valid_o && ready_i) begin
            n_xfer++;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("data", 32'(data_o), 32'(e.d));
                check("last", 32'(last_o), 32'(e.l));
            end
        end
        if (lifo_rdreq_o) begin
            n_reads++;
            check("rd_while_empty", 32'(lifo_empty_i), 32'd0);
        end
        if (busy_o) check("outstanding_le2", 32'((n_reads - n_xfer) <= 2), 32'd1);
        if (done_o) begin
            n_done++;
            done_at = cyc;
            check("done_single", 32'(prev_done), 32'd0);
        end
        prev_done = done_o;
    endtask

    task automatic tick();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        cyc++;
        case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ~ready_i;
            2:       ready_i = 1'($urandom_range(0, 1));
            default: ready_i = 1'b0;
        endcase
    endtask

    task automatic load(input int n, input int base, input int step);
        for (int i = 0; i < n; i++) begin
            vals[i] = 8'(base + step * i);
            push_en = 1'b1;
            push_d  = vals[i];
            tick();
        end
        push_en = 1'b0;
        for (int i = n - 1; i >= 0; i--) exp_q.push_back('{d: vals[i], l: (i == 0)});
    endtask

    task automatic fire_start();
        n_reads     = 0;
        n_xfer      = 0;
        first_valid = -1;
        done0       = n_done;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        start_cyc   = cyc;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300 && n_done == done0; k++) tick();
        check("burst_timeout", 32'(n_done != done0), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rdreq"}, 32'(lifo_rdreq_o), 32'd0);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_last"},  32'(last_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_done"},  32'(done_o), 32'd0);
        check({tag, "_data"},  32'(data_o), 32'd0);
    endtask

    task automatic burst_end_checks(input int n);
        tick();
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("xfer_count", 32'(n_xfer), 32'(n));
        check("read_count", 32'(n_reads), 32'(n));
        check("done_count", 32'(n_done - done0), 32'd1);
        check("busy_after", 32'(busy_o), 32'd0);
        check("lifo_drained", 32'(top), 32'd0);
    endtask

    initial begin
        vec_t vecs [0:4];
        vecs[0] = '{n: 3, mode: 0, base: 'h10, step: 'h10, exp_lat: 2, exp_done: 5};
        vecs[1] = '{n: 8, mode: 1, base: 'h01, step: 1,    exp_lat: 2, exp_done: -1};
        vecs[2] = '{n: 1, mode: 0, base: 'hAA, step: 0,    exp_lat: 2, exp_done: 3};
        vecs[3] = '{n: 5, mode: 2, base: 'h40, step: 3,    exp_lat: 2, exp_done: -1};
        vecs[4] = '{n: 8, mode: 0, base: 'hF0, step: 'h11, exp_lat: 2, exp_done: 10};

        // Reset state
        tick();
        tick();
        check_zero("reset");
        rst_n_i = 1'b1;
        tick();

        // Table of drain bursts
        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].mode;
            load(vecs[v].n, vecs[v].base, vecs[v].step);
            fire_start();
            wait_done();
            check("first_valid_lat", 32'(first_valid - start_cyc), 32'(vecs[v].exp_lat));
            if (vecs[v].exp_done >= 0)
                check("done_lat", 32'(done_at - start_cyc), 32'(vecs[v].exp_done));
            burst_end_checks(vecs[v].n);
        end

        // Start with LIFO empty is ignored
        ready_mode = 0;
        fire_start();
        repeat (6) tick();
        check("empty_start_reads", 32'(n_reads), 32'd0);
        check("empty_start_busy", 32'(busy_o), 32'd0);
        check("empty_start_done", 32'(n_done - done0), 32'd0);

        // Empty flag mid-burst stalls reads without aborting
        load(4, 'h50, 1);
        fire_start();
        force_empty = 1'b1;
        repeat (5) tick();
        check("stall_no_reads", 32'(n_reads), 32'd0);
        check("stall_busy", 32'(busy_o), 32'd1);
        force_empty = 1'b0;
        wait_done();
        burst_end_checks(4);

        // Second start during drain is ignored
        load(4, 'h60, 2);
        fire_start();
        tick();
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done();
        burst_end_checks(4);

        // Sink stalled for 10 cycles with a word valid
        ready_mode = 3;
        ready_i    = 1'b0;
        load(6, 'h70, 1);
        fire_start();
        for (int k = 0; k < 20 && first_valid < 0; k++) tick();
        check("stall_first_valid", 32'(first_valid - start_cyc), 32'd2);
        repeat (10) tick();
        check("stall_read_cap", 32'(n_reads), 32'd2);
        check("stall_valid_held", 32'(valid_o), 32'd1);
        ready_mode = 0;
        wait_done();
        burst_end_checks(6);

        // Reset after two transfers aborts the burst
        load(5, 'h80, 1);
        fire_start();
        for (int k = 0; k < 40 && n_xfer < 2; k++) tick();
        check("pre_reset_xfers", 32'(n_xfer), 32'd2);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_zero("mid_reset");
        tick();
        rst_n_i = 1'b1;
        exp_q.delete();
        hold_pend = 1'b0;
        n_reads = 0;
        n_xfer  = 0;
        repeat (6) tick();
        check("post_reset_reads", 32'(n_reads), 32'd0);
        check("post_reset_busy", 32'(busy_o), 32'd0);
        check("post_reset_valid", 32'(valid_o), 32'd0);
        lifo_clr = 1'b1;
        tick();
        lifo_clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lifo_reader.md
LIFO_READER -- requirements
Module: lifo_reader

Interface
REQ-001 Parameter DWIDTH, default 8, data word width; SHALL match the attached LIFO.
REQ-002 Parameter AWIDTH, default 3, LIFO address width; count signals SHALL be AWIDTH+1 bits wide.
REQ-003 clk_i  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n_i  in  1  reset; asynchronous and active-low.
REQ-005 start_i  in  1  one-cycle request to drain the LIFO.
REQ-006 lifo_empty_i  in  1  LIFO empty flag.
REQ-007 lifo_usedw_i  in  AWIDTH+1  LIFO occupancy.
REQ-008 lifo_q_i  in  DWIDTH  LIFO read data, valid the cycle after lifo_rdreq_o.
REQ-009 lifo_rdreq_o  out  1  LIFO pop request.
REQ-010 data_o  out  DWIDTH  stream data.
REQ-011 valid_o  out  1  stream data valid.
REQ-012 ready_i  in  1  stream sink ready.
REQ-013 last_o  out  1  marks final word of a drain burst; qualified by valid_o.
REQ-014 busy_o  out  1  high while state is DRAIN.
REQ-015 done_o  out  1  one-cycle pulse at burst completion.

Function
REQ-016 FSM states: IDLE and DRAIN only.
REQ-017 In IDLE, start_i=1 with lifo_empty_i=0: the block SHALL latch len=lifo_usedw_i, set remaining=len and sent=0, and enter DRAIN on the next cycle.
REQ-018 In IDLE, start_i=1 with lifo_empty_i=1: SHALL be ignored (no state change, no done_o).
REQ-019 In DRAIN, start_i SHALL be ignored.
REQ-020 Output buffer: 2-entry FIFO-ordered skid buffer; in-flight flag SHALL be set the cycle after each lifo_rdreq_o.
REQ-021 lifo_rdreq_o SHALL equal DRAIN & (remaining!=0) & !lifo_empty_i & (buf_cnt + inflight - pop < 2), where pop = valid_o & ready_i; combinational from registered state, lifo_empty_i and ready_i.
REQ-022 Each lifo_rdreq_o SHALL decrement remaining by 1.
REQ-023 The cycle after lifo_rdreq_o, lifo_q_i SHALL be written into the buffer tail.
REQ-024 valid_o = (buf_cnt!=0); data_o = buffer head; both registered, no combinational path from lifo_q_i.
REQ-025 A transfer occurs when valid_o & ready_i; it SHALL advance the head and increment sent.
REQ-026 last_o SHALL be high exactly when valid_o=1 and sent = len-1.
REQ-027 With ready_i held high, the first valid_o SHALL appear 2 cycles after the start_i sampling edge, and throughput SHALL be 1 word/cycle.
REQ-028 Output order SHALL equal LIFO pop order, i.e. the reverse of push order.
REQ-029 With ready_i=0, data_o/valid_o/last_o SHALL hold stable, and no word SHALL be lost or duplicated.
REQ-030 If lifo_empty_i=1 while remaining!=0, reads SHALL stall, without abort, until lifo_empty_i=0.
REQ-031 On the transfer with last_o=1, the block SHALL return to IDLE next cycle and pulse done_o for exactly that cycle.
REQ-032 Simultaneous buffer write and pop SHALL keep buf_cnt unchanged.
REQ-033 buf_cnt SHALL never exceed 2.
REQ-034 len = 2^AWIDTH (full LIFO) SHALL be handled without counter overflow.

Reset
REQ-035 rst_n_i=0 SHALL immediately force: state IDLE, buffer and in-flight flag cleared, counters 0, lifo_rdreq_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, data_o=0.
REQ-036 Reset mid-DRAIN SHALL abort the burst, discard buffered words, and issue no further reads after release until a new start_i.

Verification
REQ-037 Push 0x10,0x20,0x30; start_i; ready_i=1 -> data_o 0x30,0x20,0x10 on consecutive cycles; first valid 2 cycles after start; last_o on 0x10; done_o 1 cycle later.
REQ-038 Full LIFO (8 words 0x01..0x08), ready_i toggling 1/0 -> 0x08..0x01 in order, no drop or duplicate, buf_cnt<=2, last_o on 0x01.
REQ-039 start_i with LIFO empty -> no lifo_rdreq_o, busy_o=0, no done_o.
REQ-040 rst_n_i low after 2 of 5 words transferred -> all outputs 0 within the reset cycle; no lifo_rdreq_o after release until a new start_i.
REQ-041 start_i pulsed again mid-DRAIN -> ignored; burst length stays the original len.
REQ-042 ready_i=0 for 10 cycles with first word valid -> data_o stable, lifo_rdreq_o stops after 2 words are buffered.
